// File: rtl/sub_arbiter.sv
// sub_arbiter: shares one WIDTH-bit subtractor (F = A - B) among N_REQ
// requesters using round-robin arbitration with valid/ready handshakes.
//
// Optional build macro: SUB_ARB_SAT_EN
//   defined   -> result clamps to 0 when A < B (borrow flag still set)
//   undefined -> result wraps modulo 2^WIDTH
//
// Ports
//   clk_i         rising-edge clock
//   rst_n_i       asynchronous active-low reset
//   req_valid_i   per-requester request valid
//   req_ready_o   one-hot grant, combinational, only in IDLE
//   req_a_i       packed minuends, requester i at [i*WIDTH +: WIDTH]
//   req_b_i       packed subtrahends, same packing
//   rsp_valid_o   result valid (RESP state)
//   rsp_ready_i   result consumer ready
//   rsp_f_o       A - B
//   rsp_borrow_o  1 when A < B (unsigned)
//   rsp_id_o      index of the served requester
//   busy_o        high in EXEC or RESP
//
// state | meaning
// IDLE  | search for a winner from ptr, accept it on the edge
// EXEC  | compute and register result, borrow and id
// RESP  | present result until rsp_ready_i, then advance ptr

module sub_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_f_o,
  output logic                   rsp_borrow_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  f_q, f_d;
  logic              borrow_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     cand;
  logic [WIDTH:0]    diff;

  // Round-robin search: first valid bit starting at ptr, wrapping mod N_REQ.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!found && req_valid_i[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = cand[ID_W-1:0];
      end
    end
  end

  // Extra MSB of the difference is the unsigned borrow.
  assign diff = {1'b0, a_q} - {1'b0, b_q};

`ifdef SUB_ARB_SAT_EN
  assign f_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
  assign f_d = diff[WIDTH-1:0];
`endif

  assign ptr_d = (rsp_id_q == ID_W'(N_REQ-1)) ? '0 : rsp_id_q + 1'b1;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found)       state_d = S_EXEC;
      S_EXEC:                   state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && found) req_ready_o[win_id] = 1'b1;
    rsp_valid_o = (state_q == S_RESP);
    busy_o      = (state_q != S_IDLE);
  end

  // Datapath registers. The response id is copied in EXEC so rsp_id_o only
  // changes together with the result it belongs to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      borrow_q <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (found) begin
          a_q  <= req_a_i[int'(win_id)*WIDTH +: WIDTH];
          b_q  <= req_b_i[int'(win_id)*WIDTH +: WIDTH];
          id_q <= win_id;
        end
        S_EXEC: begin
          f_q      <= f_d;
          borrow_q <= diff[WIDTH];
          rsp_id_q <= id_q;
        end
        S_RESP: if (rsp_ready_i) ptr_q <= ptr_d;
        default: ;
      endcase
    end
  end

  assign rsp_f_o      = f_q;
  assign rsp_borrow_o = borrow_q;
  assign rsp_id_o     = rsp_id_q;

endmodule

// File: tb/tb_sub_arbiter.sv
module tb_sub_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;

`ifdef SUB_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_f;
  logic        rsp_borrow;
  logic [1:0]  rsp_id;
  logic        busy;

  sub_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_f_o      (rsp_f),
    .rsp_borrow_o (rsp_borrow),
    .rsp_id_o     (rsp_id),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  grant;
    logic [1:0]  id;
    logic [7:0]  f_wrap;
    logic        borrow;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] f;
    logic       borrow;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  function automatic exp_t mk(input logic [1:0] id, input logic [7:0] f_wrap, input logic borrow);
    exp_t e;
    e.id     = id;
    e.f      = (SAT && borrow) ? 8'h00 : f_wrap;
    e.borrow = borrow;
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL %s: response with empty scoreboard, got id %0d f %0h", tag, rsp_id, rsp_f);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
      chk({tag, "_f"}, 32'(rsp_f), 32'(e.f));
      chk({tag, "_borrow"}, 32'(rsp_borrow), 32'(e.borrow));
    end
  endtask

  // Called right after the accept cycle: drops the request, waits (bounded)
  // for the response, checks 2-cycle latency, then scores the result.
  task automatic finish_txn(input string tag);
    int cyc;
    @(negedge clk); #1;
    req_valid = 4'b0000;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd2);
    if (rsp_valid) pop_check(tag);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_f"}, 32'(rsp_f), 32'd0);
    chk({tag, "_rsp_borrow"}, 32'(rsp_borrow), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_ids[5];
    logic [7:0] held_f;
    int grants, resps, last_grant, cyc;

    // ptr starts at 0 after reset; rows are ordered so ptr history matters.
    vecs[0] = '{4'b0001, 32'h11223340, 32'h0506070A, 4'b0001, 2'd0, 8'h36, 1'b0};
    vecs[1] = '{4'b0100, 32'h10052030, 32'h01090203, 4'b0100, 2'd2, 8'hFC, 1'b1};
    vecs[2] = '{4'b0011, 32'h445566C8, 32'h01020337, 4'b0001, 2'd0, 8'h91, 1'b0};
    vecs[3] = '{4'b1001, 32'h00304050, 32'h01010101, 4'b1000, 2'd3, 8'hFF, 1'b1};
    vecs[4] = '{4'b1111, 32'h09080A07, 32'h01020307, 4'b0001, 2'd0, 8'h00, 1'b0};
    vecs[5] = '{4'b0001, 32'h010203FF, 32'h00000000, 4'b0001, 2'd0, 8'hFF, 1'b0};
    vecs[6] = '{4'b1000, 32'h80101010, 32'h81010101, 4'b1000, 2'd3, 8'hFF, 1'b1};
    vecs[7] = '{4'b0110, 32'h20306440, 32'h10100110, 4'b0010, 2'd1, 8'h63, 1'b0};

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_idle_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk_idle_zero("after_reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_a     = vecs[i].a;
      req_b     = vecs[i].b;
      #1;
      chk($sformatf("row%0d_grant", i), 32'(req_ready), 32'(vecs[i].grant));
      sb.push_back(mk(vecs[i].id, vecs[i].f_wrap, vecs[i].borrow));
      finish_txn($sformatf("row%0d", i));
    end

    // Backpressure: ptr=2, only requester 1 valid; others arrive while held.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a     = 32'h11229933;
    req_b     = 32'h00001100;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    sb.push_back(mk(2'd1, 8'h88, 1'b0));
    @(negedge clk); #1;
    req_valid = 4'b0101;
    req_a     = 32'h00507700;
    req_b     = 32'h00600000;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'd2);
    held_f = 8'h88;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_f", k), 32'(rsp_f), 32'(held_f));
      chk($sformatf("bp_hold%0d_id", k), 32'(rsp_id), 32'd1);
      chk($sformatf("bp_hold%0d_req_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_hold%0d_busy", k), 32'(busy), 32'd1);
      if (k < 4) begin
        @(negedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    if (rsp_valid) pop_check("bp");
    @(negedge clk); #1;
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    sb.push_back(mk(2'd2, 8'hF0, 1'b1));
    finish_txn("bp_next");

    // Mid-operation reset: ptr=3 now, so requester 3 wins; abort in EXEC.
    @(negedge clk);
    req_valid = 4'b1000;
    req_a     = 32'h40000000;
    req_b     = 32'h01000000;
    #1;
    chk("mr_grant", 32'(req_ready), 32'b1000);
    @(negedge clk); #1;
    req_valid = 4'b0000;
    chk("mr_busy_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy_async", 32'(busy), 32'd0);
    chk("mr_rsp_valid_async", 32'(rsp_valid), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("mr_rsp_valid_held", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;

    // Round-robin from a freshly reset ptr: 0,1,2,3,0, one grant per 3 cycles.
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    req_valid = 4'b1111;
    req_a     = 32'h40302010;
    req_b     = 32'h04030201;
    #1;
    grants = 0; resps = 0; last_grant = 0; cyc = 0;
    while (resps < 5 && cyc < 40) begin
      if (req_ready != 4'b0000 && grants < 5) begin
        chk($sformatf("rr%0d_grant", grants), 32'(req_ready), 32'(4'b0001 << rr_ids[grants]));
        if (grants > 0) chk($sformatf("rr%0d_gap", grants), 32'(cyc - last_grant), 32'd3);
        last_grant = cyc;
        sb.push_back(mk(rr_ids[grants], 8'((int'(rr_ids[grants]) + 1) * 15), 1'b0));
        grants++;
      end
      if (rsp_valid) begin
        pop_check($sformatf("rr%0d", resps));
        resps++;
      end
      @(negedge clk);
      if (grants == 5) req_valid = 4'b0000;
      #1;
      cyc++;
    end
    chk("rr_responses", 32'(resps), 32'd5);
    chk("rr_final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
